// File: rtl/perf_ctrl_host.sv
// perf_ctrl_host: command front-end for the cycle counter; issues control writes and tear-free hi-lo-hi 64-bit snapshots.
module perf_ctrl_host #(
   parameter int         MAX_RETRY = 2,
   parameter logic [3:0] ADDR_HI   = 4'h0,
   parameter logic [3:0] ADDR_LO   = 4'h4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   input  logic [1:0]  cmd_op_i,
   output logic        cmd_ready_o,
   output logic        snap_valid_o,
   output logic [63:0] snap_data_o,
   output logic        snap_err_o,
   output logic        running_o,
   output logic [3:0]  pc_addr_o,
   output logic [2:0]  pc_wdata_o,
   output logic        pc_w_en_o,
   input  logic [31:0] pc_rdata_i
);
   localparam int RW = $clog2(MAX_RETRY + 2);
   typedef enum logic [2:0] {IDLE, WR, HI1, LO, HI2, CHK, DONE} state_t;
   state_t        state_q, state_d;
   logic [2:0]    wdata_q, wdata_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [31:0]   hi1_q, hi1_d, lo_q, lo_d;
   logic [63:0]   snap_q, snap_d;
   logic          err_q, err_d, running_q, running_d;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         wdata_q   <= '0;
         retry_q   <= '0;
         hi1_q     <= '0;
         lo_q      <= '0;
         snap_q    <= '0;
         err_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wdata_q   <= wdata_d;
         retry_q   <= retry_d;
         hi1_q     <= hi1_d;
         lo_q      <= lo_d;
         snap_q    <= snap_d;
         err_q     <= err_d;
         running_q <= running_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      wdata_d   = wdata_q;
      retry_d   = retry_q;
      hi1_d     = hi1_q;
      lo_d      = lo_q;
      snap_d    = snap_q;
      err_d     = err_q;
      running_d = running_q;
      case (state_q)
         IDLE: if (cmd_valid_i) begin
            state_d = (cmd_op_i == 2'd3) ? HI1 : WR;
            wdata_d = {1'b0, cmd_op_i};
            retry_d = '0;
         end
         WR: begin
            running_d = (wdata_q == 3'd1);
            state_d   = IDLE;
         end
         HI1: state_d = LO;
         LO: begin
            hi1_d   = pc_rdata_i;
            state_d = HI2;
         end
         HI2: begin
            lo_d    = pc_rdata_i;
            state_d = CHK;
         end
         // pc_rdata_i now carries the second hi read; a differing hi word means lo wrapped in between
         CHK: begin
            if (hi1_q == pc_rdata_i) begin
               snap_d  = {hi1_q, lo_q};
               err_d   = 1'b0;
               state_d = DONE;
            end else if (retry_q != RW'(MAX_RETRY)) begin
               retry_d = retry_q + RW'(1);
               state_d = HI1;
            end else begin
               snap_d  = {pc_rdata_i, 32'h0};
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign cmd_ready_o  = (state_q == IDLE);
   assign snap_valid_o = (state_q == DONE);
   assign snap_data_o  = snap_q;
   assign snap_err_o   = err_q;
   assign running_o    = running_q;
   assign pc_addr_o    = (state_q == LO) ? ADDR_LO : ADDR_HI;
   assign pc_wdata_o   = (state_q == WR) ? wdata_q : 3'd0;
   assign pc_w_en_o    = (state_q == WR);
endmodule

// File: tb/tb_perf_ctrl_host.sv
// tb_perf_ctrl_host: directed checks of perf_ctrl_host against a simple cycle-counter model (default and zero-retry instances).
module tb_perf_ctrl_host;
   logic        clk, rst, cmd_valid, ld, inc;
   logic [1:0]  cmd_op;
   logic [63:0] cnt, ld_val;
   logic        rdy0, sv0, se0, run0, wen0, rdy1, sv1, se1, run1, wen1;
   logic [63:0] sd0, sd1;
   logic [3:0]  addr0, addr1;
   logic [2:0]  wd0, wd1;
   logic [31:0] rd0, rd1;
   int n_cmp = 0, n_fail = 0;

   perf_ctrl_host dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op),
      .cmd_ready_o(rdy0), .snap_valid_o(sv0), .snap_data_o(sd0), .snap_err_o(se0),
      .running_o(run0), .pc_addr_o(addr0), .pc_wdata_o(wd0), .pc_w_en_o(wen0),
      .pc_rdata_i(rd0));

   perf_ctrl_host #(.MAX_RETRY(0)) dut_e (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op),
      .cmd_ready_o(rdy1), .snap_valid_o(sv1), .snap_data_o(sd1), .snap_err_o(se1),
      .running_o(run1), .pc_addr_o(addr1), .pc_wdata_o(wd1), .pc_w_en_o(wen1),
      .pc_rdata_i(rd1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counter model: one-cycle registered read of whichever address each controller presents
   always @(posedge clk) begin
      cnt <= ld ? ld_val : cnt + {63'd0, inc};
      rd0 <= (addr0 == 4'h0) ? cnt[63:32] : cnt[31:0];
      rd1 <= (addr1 == 4'h0) ? cnt[63:32] : cnt[31:0];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_wr(input logic [1:0] op, input logic [2:0] exp_wd, input logic exp_run);
      cmd_valid = 1'b1;
      cmd_op    = op;
      chk("wr_ready_idle", 64'(rdy0), 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("wr_en", 64'(wen0), 64'd1);
      chk("wr_addr", 64'(addr0), 64'h0);
      chk("wr_wdata", 64'(wd0), 64'(exp_wd));
      chk("wr_ready_busy", 64'(rdy0), 64'd0);
      @(negedge clk);
      chk("wr_en_after", 64'(wen0), 64'd0);
      chk("wr_running", 64'(run0), 64'(exp_run));
      chk("wr_ready_back", 64'(rdy0), 64'd1);
   endtask

   task automatic snap(input logic [63:0] v, input logic run,
                       input int l0, input logic [63:0] d0, input logic e0,
                       input int l1, input logic [63:0] d1, input logic e1);
      int f0 = 0, f1 = 0;
      logic [63:0] s0 = '0, s1 = '0;
      logic r0 = 1'b0, r1 = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      ld        = 1'b1;
      ld_val    = v;
      inc       = run;
      @(negedge clk);
      cmd_valid = 1'b0;
      ld        = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (sv0 && f0 == 0) begin f0 = k; s0 = sd0; r0 = se0; end
         if (sv1 && f1 == 0) begin f1 = k; s1 = sd1; r1 = se1; end
         @(negedge clk);
      end
      inc = 1'b0;
      chk("snap_latency", 64'(f0), 64'(l0));
      chk("snap_data", s0, d0);
      chk("snap_err", 64'(r0), 64'(e0));
      chk("snap0r_latency", 64'(f1), 64'(l1));
      chk("snap0r_data", s1, d1);
      chk("snap0r_err", 64'(r1), 64'(e1));
   endtask

   initial begin
      int rdy_at, w_at, w_cnt, v_cnt;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; ld = 1'b1; ld_val = '0; inc = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(rdy0), 64'd1);
      chk("rst_valid", 64'(sv0), 64'd0);
      chk("rst_data", sd0, 64'd0);
      chk("rst_err", 64'(se0), 64'd0);
      chk("rst_running", 64'(run0), 64'd0);
      chk("rst_addr", 64'(addr0), 64'h0);
      chk("rst_wdata", 64'(wd0), 64'd0);
      chk("rst_wen", 64'(wen0), 64'd0);
      rst = 1'b0;
      ld  = 1'b0;
      @(negedge clk);

      do_wr(2'd1, 3'b001, 1'b1);
      do_wr(2'd2, 3'b010, 1'b0);
      do_wr(2'd1, 3'b001, 1'b1);
      do_wr(2'd0, 3'b000, 1'b0);

      snap(64'h0000_0012_3456_789A, 1'b0, 5, 64'h0000_0012_3456_789A, 1'b0,
           5, 64'h0000_0012_3456_789A, 1'b0);
      snap(64'h0000_0001_FFFF_FFFE, 1'b1, 9, 64'h0000_0002_0000_0003, 1'b0,
           5, 64'h0000_0002_0000_0000, 1'b1);

      // run request held while a snapshot is in flight
      rdy_at = 0; w_at = 0; w_cnt = 0;
      cmd_valid = 1'b1; cmd_op = 2'd3; ld = 1'b1; ld_val = 64'h55;
      @(negedge clk);
      ld = 1'b0; cmd_op = 2'd1;
      for (int k = 1; k <= 10; k++) begin
         if (rdy0 && rdy_at == 0) rdy_at = k;
         if (wen0) begin w_cnt++; if (w_at == 0) w_at = k; end
         if (k == 5) begin
            chk("busy_snap_valid", 64'(sv0), 64'd1);
            chk("busy_snap_data", sd0, 64'h55);
         end
         if (k == 7) cmd_valid = 1'b0;
         @(negedge clk);
      end
      chk("busy_ready_cycle", 64'(rdy_at), 64'd6);
      chk("busy_write_cycle", 64'(w_at), 64'd7);
      chk("busy_write_count", 64'(w_cnt), 64'd1);
      chk("busy_running", 64'(run0), 64'd1);

      // reset in the middle of HI2
      cmd_valid = 1'b1; cmd_op = 2'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 64'(rdy0), 64'd1);
      chk("mid_rst_valid", 64'(sv0), 64'd0);
      chk("mid_rst_data", sd0, 64'd0);
      chk("mid_rst_err", 64'(se0), 64'd0);
      chk("mid_rst_running", 64'(run0), 64'd0);
      chk("mid_rst_addr", 64'(addr0), 64'h0);
      chk("mid_rst_wen", 64'(wen0), 64'd0);
      rst = 1'b0;
      v_cnt = 0; w_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (sv0) v_cnt++;
         if (wen0) w_cnt++;
         @(negedge clk);
      end
      chk("mid_rst_no_valid", 64'(v_cnt), 64'd0);
      chk("mid_rst_no_write", 64'(w_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/perf_ctrl_host.md
Name: perf_ctrl_host

Overview:
- Initiator-side controller for the cycle-counter register interface (4-bit address, 3-bit write data, write enable, 32-bit registered read data).
- Accepts simple commands from the core or debug logic: clear, run, hold, snapshot.
- Turns each command into counter-interface writes or reads.
- Returns tear-free 64-bit counter snapshots using a hi-lo-hi read sequence with bounded retry.

Parameters:
- MAX_RETRY, 2, maximum re-reads after a hi-word mismatch before the snapshot is flagged as an error.
- ADDR_HI, 4'h0, counter address that returns mcycle[63:32] and accepts control writes.
- ADDR_LO, 4'h4, counter address that returns mcycle[31:0].

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  command request.
- cmd_op_i  input  2  0=clear, 1=run, 2=hold, 3=snapshot.
- cmd_ready_o  output  1  high only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o.
- snap_valid_o  output  1  one-cycle pulse when snap_data_o is updated.
- snap_data_o  output  64  last snapshot; held until the next snapshot completes.
- snap_err_o  output  1  qualifies the last snapshot as inconsistent; updated together with snap_data_o.
- running_o  output  1  1 after an accepted run; 0 after clear or hold.
- pc_addr_o  output  4  counter address.
- pc_wdata_o  output  3  counter write data.
- pc_w_en_o  output  1  counter write enable.
- pc_rdata_i  input  32  counter read data; reflects the pc_addr_o sampled at the previous rising edge (1-cycle latency).

Behaviour:
- Reset: rst_i asserted, asynchronously:
  - state=IDLE; retry count=0.
  - All outputs 0: cmd_ready_o becomes 1 once in IDLE, which is immediate; snap_data_o=0, snap_err_o=0, running_o=0.
  - pc_addr_o=ADDR_HI, pc_wdata_o=0, pc_w_en_o=0.
- Reset mid-sequence: abort, no snap_valid_o pulse, no counter write issued.
- Registered outputs: all outputs are driven from registers or decoded from state only; no combinational path from cmd_* or pc_rdata_i to any output.
- States: IDLE, WR, HI1, LO, HI2, CHK, DONE.
- IDLE:
  - cmd_ready_o=1, pc_w_en_o=0, pc_addr_o=ADDR_HI.
  - Accept with op 0/1/2 -> WR; latch wdata={1'b0, op[1:0]}, where op 2 maps to ctrl 2 (hold).
  - Accept with op 3 -> HI1; retry count cleared.
- WR (one cycle):
  - pc_w_en_o=1, pc_addr_o=ADDR_HI, pc_wdata_o=latched value.
  - running_o updates at the end of this cycle.
  - Next state: IDLE.
  - Accept-to-write latency: 1 cycle.
- HI1: pc_addr_o=ADDR_HI. Next: LO.
- LO: pc_addr_o=ADDR_LO; capture hi1=pc_rdata_i at end of cycle. Next: HI2.
- HI2: pc_addr_o=ADDR_HI; capture lo=pc_rdata_i. Next: CHK.
- CHK: hi2=pc_rdata_i.
  - hi1==hi2 -> result {hi1, lo}, err=0, go to DONE.
  - Else if retry<MAX_RETRY -> retry+1, go to HI1.
  - Else -> result {hi2, 32'h0}, err=1, go to DONE.
- DONE (one cycle):
  - snap_valid_o=1; snap_data_o and snap_err_o take the result at the start of this cycle.
  - Next state: IDLE.
- Snapshot latency with no retry: snap_valid_o high in the 5th cycle after the accept cycle. Each retry adds 4 cycles.
- Busy behaviour: cmd_valid_i while not IDLE is ignored (cmd_ready_o=0). The command must be held by the requester.
- Back-to-back: a new command can be accepted in the IDLE cycle right after WR or DONE.
- Wrap-around: the full 64-bit compare uses only the hi words. A low-word carry between hi1 and hi2 forces a retry. With the counter incrementing at most once per cycle, one retry always suffices; MAX_RETRY=0 makes every carry an error.
- Held counter (ctrl=2) or cleared counter: hi1==hi2 always; the snapshot is exact.

Test Plan:
- Reset values: assert rst_i mid-HI2 -> next cycle all outputs 0, cmd_ready_o=1, pc_addr_o=0, no snap_valid_o pulse.
- Command writes:
  - op=1 -> one cycle with pc_w_en_o=1, pc_addr_o=0, pc_wdata_o=3'b001; running_o=1.
  - op=0 -> pc_wdata_o=3'b000; running_o=0.
- Held snapshot: counter model held at 0x0000_0012_3456_789A, op=3 -> snap_valid_o pulse 5 cycles after accept, snap_data_o=0x0000_0012_3456_789A, snap_err_o=0.
- Carry retry: counter running, value sampled at the HI1 edge = 0x0000_0001_FFFF_FFFE:
  - First pass reads hi1=1, lo=0xFFFF_FFFF, hi2=2 -> mismatch, retry.
  - Retry yields snap_data_o=0x0000_0002_0000_0003, snap_err_o=0, valid at accept+9.
- Error path: MAX_RETRY=0 with the same carry stimulus -> snap_data_o=0x0000_0002_0000_0000, snap_err_o=1.
- Busy: cmd_valid_i held with op=1 during a snapshot -> cmd_ready_o=0 until IDLE; the write is issued the cycle after the IDLE accept; exactly one pc_w_en_o pulse.
